uart_tx_buf: RTL and testbench
==============================

Name: uart_tx_buf

Overview:
Parametrised UART transmitter with an internal transmit FIFO and a valid/ready write interface. Supports runtime-selectable data length, five parity modes and 1/1.5/2 stop bits. Runs on the oversampled bit clock used by the UART datapath and drives the serial TX pin. Frames go out back-to-back while the FIFO holds data.

Parameters:
OVS, 16, oversample clocks per bit; even, minimum 4.
DW_MAX, 9, maximum data bits per frame; range 8..9.
FIFO_DEPTH, 8, transmit FIFO entries; power of two, minimum 2.

Ports:
i_clk_ovs  in  1  oversampled clock, OVS ticks per bit.
i_rst_n  in  1  asynchronous active-low reset.
i_bitnum  in  4  data bits per frame, 5..DW_MAX.
i_parity_mode  in  3  0 none, 1 odd, 2 even, 3 mark, 4 space; 5..7 treated as none.
i_stop_mode  in  2  0 one, 1 one-and-half, 2 two; 3 treated as two.
i_data  in  DW_MAX  frame data, LSB sent first.
i_data_valid  in  1  write request.
o_data_ready  out  1  FIFO can accept a write (= not full).
o_tx  out  1  serial line, registered, idle high.
o_busy  out  1  high in any state other than IDLE.
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
o_frame_done  out  1  one-cycle pulse on the last tick of each frame.

Behaviour:
- Clock and reset: one clock (i_clk_ovs); reset asynchronous, active-low (i_rst_n).
- Reset values: o_tx=1, o_busy=0, o_frame_done=0, o_fifo_level=0, o_data_ready=1. FIFO is emptied and the FSM goes to IDLE.
- Reset mid-frame aborts the frame immediately; o_tx returns high asynchronously.
- Write: a push occurs when i_data_valid & o_data_ready. i_data_valid while full is ignored and never overwrites data.
- Push and pop in the same cycle leave the level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when the FIFO is not empty. On that cycle the head entry is popped and i_bitnum, i_parity_mode and i_stop_mode are latched for the whole frame.
- o_tx goes to 0 on the cycle after the pop (1-cycle latency). Later config changes do not affect the frame in flight.
- Each START, DATA and PARITY bit lasts exactly OVS cycles, counted by a tick counter of width $clog2(OVS).
- DATA sends the latched bits LSB first. Latched bitnum <5 is clamped to 5; >DW_MAX is clamped to DW_MAX.
- PARITY is present only when mode is 1..4:
  - odd: ~^data[bitnum-1:0]
  - even: ^data[bitnum-1:0]
  - mark: 1
  - space: 0
  - Parity is computed only over the active bits.
- STOP drives o_tx=1 for OVS, 3*OVS/2 or 2*OVS cycles according to the latched stop mode.
- On the last STOP tick o_frame_done pulses. The FSM then goes to START directly if the FIFO is not empty (no idle gap, pop on this cycle); otherwise it goes to IDLE.
- o_busy is deasserted only in IDLE.

Optional Feature:
UART_TX_BREAK_EN:
- Defined:
  - Adds input i_break and a BREAK state.
  - If i_break is high in IDLE, or at the end of STOP, the FSM enters BREAK and holds o_tx=0 and o_busy=1 while i_break stays high; the FIFO is not popped.
  - On release, o_tx=1 for at least 2*OVS cycles (mark-after-break) before the next START.
  - A frame in progress always completes before BREAK is entered.
- Undefined: no i_break port and no BREAK state.

Decomposition:
- Package uart_pkg holds:
  - parity-mode and stop-mode encodings;
  - FSM state typedef (BREAK code reserved);
  - clamp limits for bitnum.
- Sub-module uart_tx_fifo: synchronous FIFO, DW_MAX wide, FIFO_DEPTH deep, with push/pop/full/empty/level outputs.
- FSM, tick counter, bit counter, shifter and parity live in uart_tx_buf.

Test Plan:
- 8N1, OVS=16, push 0x55 -> o_tx 0 then 1,0,1,0,1,0,1,0, then 1; each level held 16 cycles; o_frame_done pulses at cycle 160 after the pop.
- 8E1, push 0xA5 -> parity bit 0; 8O1 with 0xA5 -> parity 1; mark mode -> 1, space mode -> 0; frame is 176 cycles.
- 7N1.5 with 0xFF -> 7 data ones, bit 7 not sent, stop held 24 cycles; bitnum=3 behaves as 5 bits.
- Fill FIFO_DEPTH=8 with 0x01..0x08 plus a 9th write while full -> o_data_ready=0, 9th word dropped; 8 frames back-to-back with no idle gap; o_fifo_level counts down 8..0; o_busy drops after the last stop.
- Change i_bitnum/parity mid-frame -> current frame unchanged, next frame uses the new config. Assert i_rst_n low mid-DATA -> o_tx=1 immediately, level=0, and no frame after release.
- With UART_TX_BREAK_EN: i_break high 100 cycles during a frame -> frame completes, o_tx low until release, then high 32 cycles minimum before the next start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings, FSM state type and helpers for the buffered UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      PAR_NONE  = 3'd0,
      PAR_ODD   = 3'd1,
      PAR_EVEN  = 3'd2,
      PAR_MARK  = 3'd3,
      PAR_SPACE = 3'd4
   } parity_mode_e;

   typedef enum logic [1:0] {
      STOP_1   = 2'd0,
      STOP_1P5 = 2'd1,
      STOP_2   = 2'd2
   } stop_mode_e;

   // ST_BREAK is only reachable when the break feature is compiled in.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } tx_state_e;

   localparam logic [3:0] BITNUM_MIN    = 4'd5;
   localparam logic [1:0] MAB_LAST_HALF = 2'd3;

   function automatic logic [3:0] clamp_bitnum(input logic [3:0] b, input logic [3:0] max_b);
      if (b < BITNUM_MIN) return BITNUM_MIN;
      if (b > max_b)      return max_b;
      return b;
   endfunction

   function automatic logic parity_enabled(input logic [2:0] mode);
      return (mode == PAR_ODD) || (mode == PAR_EVEN) || (mode == PAR_MARK) || (mode == PAR_SPACE);
   endfunction

   function automatic logic parity_value(input logic [2:0] mode, input logic data_xor);
      case (mode)
         PAR_ODD:  return ~data_xor;
         PAR_EVEN: return data_xor;
         PAR_MARK: return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

   // Stop time is counted in half-bit units; returns the index of the last half.
   function automatic logic [1:0] stop_last_half(input logic [1:0] mode);
      case (mode)
         STOP_1:   return 2'd1;
         STOP_1P5: return 2'd2;
         default:  return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Write-side valid/ready handshake of the buffered UART transmitter.
interface uart_tx_buf_if #(
   parameter int unsigned DW_MAX = 9
);
   logic [DW_MAX-1:0] i_data;
   logic              i_data_valid;
   logic              o_data_ready;

   modport master (output i_data, output i_data_valid, input o_data_ready);
   modport slave  (input i_data, input i_data_valid, output o_data_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO; writes while full and reads while empty are ignored.
module uart_tx_fifo #(
   parameter int unsigned DW    = 9,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [DW-1:0]            wdata_i,
   output logic [DW-1:0]            rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push_ok, pop_ok;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO-fed frame FSM with runtime data/parity/stop config.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int unsigned OVS        = 16,
   parameter int unsigned DW_MAX     = 9,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          i_clk_ovs,
   input  logic                          i_rst_n,
   input  logic [3:0]                    i_bitnum,
   input  logic [2:0]                    i_parity_mode,
   input  logic [1:0]                    i_stop_mode,
   uart_tx_buf_if.slave                  wr_if,
`ifdef UART_TX_BREAK_EN
   input  logic                          i_break,
`endif
   output logic                          o_tx,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_frame_done
);

   localparam int unsigned TW = $clog2(OVS);
   typedef logic [TW-1:0] tick_t;
   localparam tick_t BIT_LAST  = tick_t'(OVS - 1);
   localparam tick_t HALF_LAST = tick_t'(OVS / 2 - 1);

   tx_state_e         state_q, state_d;
   tick_t             tick_q, tick_d;
   logic [3:0]        bit_q, bit_d;
   logic [DW_MAX-1:0] sh_q, sh_d;
   logic [3:0]        nbits_q, nbits_d;
   logic              par_en_q, par_en_d;
   logic              par_bit_q, par_bit_d;
   logic [1:0]        stop_last_q, stop_last_d;
   logic              tx_q, tx_d;
`ifdef UART_TX_BREAK_EN
   logic              brk_rel_q, brk_rel_d;
   logic              enter_break;
`endif

   logic [DW_MAX-1:0] fifo_rdata;
   logic              fifo_full, fifo_empty, fifo_pop;
   logic              start_frame, frame_done;
   logic [3:0]        nb_clamp;
   logic [DW_MAX-1:0] act_mask;
   logic              par_xor;

   uart_tx_fifo #(
      .DW    (DW_MAX),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (i_clk_ovs),
      .rst_ni  (i_rst_n),
      .push_i  (wr_if.i_data_valid),
      .pop_i   (fifo_pop),
      .wdata_i (wr_if.i_data),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (o_fifo_level)
   );

   assign wr_if.o_data_ready = ~fifo_full;
   assign o_tx               = tx_q;
   assign o_busy             = (state_q != ST_IDLE);
   assign o_frame_done       = frame_done;

   // Parity is taken from the head entry at pop time, over the clamped bit count only.
   always_comb begin
      nb_clamp = clamp_bitnum(i_bitnum, 4'(DW_MAX));
      for (int unsigned i = 0; i < DW_MAX; i++) begin
         act_mask[i] = (i < 32'(nb_clamp));
      end
      par_xor = ^(fifo_rdata & act_mask);
   end

   // tx_d reflects the state being entered so o_tx is registered with no extra lag.
   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q + tick_t'(1);
      bit_d       = bit_q;
      sh_d        = sh_q;
      nbits_d     = nbits_q;
      par_en_d    = par_en_q;
      par_bit_d   = par_bit_q;
      stop_last_d = stop_last_q;
      tx_d        = 1'b1;
      fifo_pop    = 1'b0;
      frame_done  = 1'b0;
      start_frame = 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_rel_d   = brk_rel_q;
      enter_break = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            tick_d = '0;
`ifdef UART_TX_BREAK_EN
            if (i_break) enter_break = 1'b1;
            else if (!fifo_empty) start_frame = 1'b1;
`else
            if (!fifo_empty) start_frame = 1'b1;
`endif
         end
         ST_START: begin
            tx_d = 1'b0;
            if (tick_q == BIT_LAST) begin
               tick_d  = '0;
               state_d = ST_DATA;
               tx_d    = sh_q[0];
            end
         end
         ST_DATA: begin
            tx_d = sh_q[0];
            if (tick_q == BIT_LAST) begin
               tick_d = '0;
               sh_d   = sh_q >> 1;
               if (bit_q == nbits_q - 4'd1) begin
                  bit_d = '0;
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
                  tx_d  = sh_d[0];
               end
            end
         end
         ST_PARITY: begin
            tx_d = par_bit_q;
            if (tick_q == BIT_LAST) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (tick_q == HALF_LAST) begin
               tick_d = '0;
               bit_d  = bit_q + 4'd1;
               if (bit_q == {2'b00, stop_last_q}) begin
                  frame_done = 1'b1;
                  bit_d      = '0;
                  state_d    = ST_IDLE;
`ifdef UART_TX_BREAK_EN
                  if (i_break) enter_break = 1'b1;
                  else if (!fifo_empty) start_frame = 1'b1;
`else
                  if (!fifo_empty) start_frame = 1'b1;
`endif
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         // Hold low while break is asserted, then mark for two bit times before idling.
         ST_BREAK: begin
            if (!brk_rel_q) begin
               tx_d   = 1'b0;
               tick_d = '0;
               bit_d  = '0;
               if (!i_break) begin
                  brk_rel_d = 1'b1;
                  tx_d      = 1'b1;
               end
            end else if (i_break) begin
               brk_rel_d = 1'b0;
               tx_d      = 1'b0;
               tick_d    = '0;
               bit_d     = '0;
            end else begin
               tx_d = 1'b1;
               if (tick_q == HALF_LAST) begin
                  tick_d = '0;
                  bit_d  = bit_q + 4'd1;
                  if (bit_q == {2'b00, MAB_LAST_HALF}) begin
                     bit_d     = '0;
                     brk_rel_d = 1'b0;
                     state_d   = ST_IDLE;
                  end
               end
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            tick_d  = '0;
            bit_d   = '0;
         end
      endcase

`ifdef UART_TX_BREAK_EN
      if (enter_break) begin
         state_d   = ST_BREAK;
         tx_d      = 1'b0;
         tick_d    = '0;
         bit_d     = '0;
         brk_rel_d = 1'b0;
      end
`endif

      if (start_frame) begin
         fifo_pop    = 1'b1;
         state_d     = ST_START;
         tick_d      = '0;
         bit_d       = '0;
         sh_d        = fifo_rdata;
         nbits_d     = nb_clamp;
         par_en_d    = parity_enabled(i_parity_mode);
         par_bit_d   = parity_value(i_parity_mode, par_xor);
         stop_last_d = stop_last_half(i_stop_mode);
         tx_d        = 1'b0;
      end
   end

   always_ff @(posedge i_clk_ovs or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         tick_q      <= '0;
         bit_q       <= '0;
         sh_q        <= '0;
         nbits_q     <= BITNUM_MIN;
         par_en_q    <= 1'b0;
         par_bit_q   <= 1'b0;
         stop_last_q <= '0;
         tx_q        <= 1'b1;
`ifdef UART_TX_BREAK_EN
         brk_rel_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         sh_q        <= sh_d;
         nbits_q     <= nbits_d;
         par_en_q    <= par_en_d;
         par_bit_q   <= par_bit_d;
         stop_last_q <= stop_last_d;
         tx_q        <= tx_d;
`ifdef UART_TX_BREAK_EN
         brk_rel_q   <= brk_rel_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed self-checking bench for uart_tx_buf (OVS=16, DW_MAX=9, FIFO_DEPTH=8).
module tb_uart_tx_buf;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] bitnum = 4'd8;
   logic [2:0] pmode = 3'd0;
   logic [1:0] smode = 2'd0;
   logic       tx, busy, done;
   logic [3:0] level;
`ifdef UART_TX_BREAK_EN
   logic       brk = 1'b0;
`endif
   int checks = 0;
   int errors = 0;

   uart_tx_buf_if #(.DW_MAX(9)) wr_if ();

   uart_tx_buf #(
      .OVS        (16),
      .DW_MAX     (9),
      .FIFO_DEPTH (8)
   ) dut (
      .i_clk_ovs     (clk),
      .i_rst_n       (rst_n),
      .i_bitnum      (bitnum),
      .i_parity_mode (pmode),
      .i_stop_mode   (smode),
      .wr_if         (wr_if),
`ifdef UART_TX_BREAK_EN
      .i_break       (brk),
`endif
      .o_tx          (tx),
      .o_busy        (busy),
      .o_fifo_level  (level),
      .o_frame_done  (done)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   function automatic int bad(input logic [0:399] w, input int s, input int len, input logic lv);
      int n = 0;
      for (int i = s; i < s + len; i++) if (w[i] !== lv) n++;
      return n;
   endfunction

   function automatic int first_done(input logic [0:399] d);
      for (int i = 0; i < 400; i++) if (d[i] === 1'b1) return i;
      return -1;
   endfunction

   task automatic push(input logic [8:0] v);
      @(negedge clk);
      wr_if.i_data       = v;
      wr_if.i_data_valid = 1'b1;
      @(negedge clk);
      wr_if.i_data_valid = 1'b0;
   endtask

   task automatic set_cfg(input logic [3:0] b, input logic [2:0] p, input logic [1:0] s);
      @(negedge clk);
      bitnum = b;
      pmode  = p;
      smode  = s;
   endtask

   // Index 0 is the first sample with o_tx low (cycle after the pop).
   task automatic capture(input int n, output logic [0:399] w, output logic [0:399] d, output bit ok);
      ok = 1'b0;
      w  = '1;
      d  = '0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) return;
      w[0] = tx;
      d[0] = done;
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         w[i] = tx;
         d[i] = done;
      end
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         if (busy === 1'b0 && level === 4'd0) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_idle got=busy want=idle");
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx got=%b want=1", tx); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", level); end
      checks++; if (wr_if.o_data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", wr_if.o_data_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_8n1();
      logic [0:399] w, d;
      bit ok;
      int n;
      logic [7:0] v;
      v = 8'h55;
      set_cfg(4'd8, 3'd0, 2'd0);
      push(9'h055);
      capture(200, w, d, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL 8n1_start got=none want=start_bit"); return; end
      n = bad(w, 0, 16, 1'b0);
      checks++; if (n != 0) begin errors++; $display("FAIL 8n1_start_bit got=%0d_bad_cycles want=0", n); end
      for (int b = 0; b < 8; b++) begin
         n = bad(w, 16 + 16 * b, 16, v[b]);
         checks++; if (n != 0) begin errors++; $display("FAIL 8n1_data bit=%0d got=%0d_bad_cycles want=0 level=%b", b, n, v[b]); end
      end
      n = bad(w, 144, 56, 1'b1);
      checks++; if (n != 0) begin errors++; $display("FAIL 8n1_stop_idle got=%0d_bad_cycles want=0", n); end
      n = first_done(d);
      checks++; if (n != 159) begin errors++; $display("FAIL 8n1_frame_done got=%0d want=159", n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy_after got=%b want=0", busy); end
   endtask

   task automatic test_parity();
      logic [2:0] modes [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
      logic       exps  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [0:399] w, d;
      bit ok;
      int n;
      for (int m = 0; m < 4; m++) begin
         wait_idle();
         set_cfg(4'd8, modes[m], 2'd0);
         push(9'h0A5);
         capture(180, w, d, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL parity_start mode=%0d got=none want=start_bit", modes[m]); continue; end
         n = bad(w, 144, 16, exps[m]);
         checks++; if (n != 0) begin errors++; $display("FAIL parity_bit mode=%0d got=%0d_bad_cycles want=%b", modes[m], n, exps[m]); end
         n = bad(w, 160, 16, 1'b1);
         checks++; if (n != 0) begin errors++; $display("FAIL parity_stop mode=%0d got=%0d_bad_cycles want=0", modes[m], n); end
         n = first_done(d);
         checks++; if (n != 175) begin errors++; $display("FAIL parity_frame_done mode=%0d got=%0d want=175", modes[m], n); end
      end
   endtask

   task automatic test_short_frames();
      logic [0:399] w, d;
      bit ok;
      int n;
      logic [4:0] v;
      wait_idle();
      set_cfg(4'd7, 3'd0, 2'd1);
      push(9'h0FF);
      capture(200, w, d, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL 7n15_start got=none want=start_bit"); return; end
      n = bad(w, 16, 136, 1'b1);
      checks++; if (n != 0) begin errors++; $display("FAIL 7n15_data_stop got=%0d_bad_cycles want=0", n); end
      n = first_done(d);
      checks++; if (n != 151) begin errors++; $display("FAIL 7n15_frame_done got=%0d want=151", n); end

      wait_idle();
      v = 5'b11110;
      set_cfg(4'd3, 3'd0, 2'd0);
      push(9'h01E);
      capture(140, w, d, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL clamp5_start got=none want=start_bit"); return; end
      for (int b = 0; b < 5; b++) begin
         n = bad(w, 16 + 16 * b, 16, v[b]);
         checks++; if (n != 0) begin errors++; $display("FAIL clamp5_data bit=%0d got=%0d_bad_cycles want=0", b, n); end
      end
      n = bad(w, 96, 44, 1'b1);
      checks++; if (n != 0) begin errors++; $display("FAIL clamp5_stop got=%0d_bad_cycles want=0", n); end
      n = first_done(d);
      checks++; if (n != 111) begin errors++; $display("FAIL clamp5_frame_done got=%0d want=111", n); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      bit found;
      wait_idle();
      set_cfg(4'd8, 3'd0, 2'd0);
      push(9'h000);
      for (int k = 1; k <= 8; k++) push(9'(k));
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL fill_level got=%0d want=8", level); end
      checks++; if (wr_if.o_data_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b want=0", wr_if.o_data_ready); end
      push(9'h009);
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_write_level got=%0d want=8", level); end
      for (int k = 0; k < 9; k++) begin
         found = 1'b0;
         for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin found = 1'b1; break; end
         end
         checks++;
         if (!found) begin errors++; $display("FAIL b2b_done frame=%0d got=none want=pulse", k); return; end
         checks++; if (level !== 4'(8 - k)) begin errors++; $display("FAIL b2b_level frame=%0d got=%0d want=%0d", k, level, 8 - k); end
         @(negedge clk);
         if (k < 8) begin
            checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_gap frame=%0d got=%b want=0", k + 1, tx); end
            repeat (24) @(negedge clk);
            v[0] = tx;
            for (int b = 1; b < 8; b++) begin
               repeat (16) @(negedge clk);
               v[b] = tx;
            end
            checks++; if (v !== 8'(k + 1)) begin errors++; $display("FAIL b2b_data frame=%0d got=%h want=%h", k + 1, v, 8'(k + 1)); end
         end else begin
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || level !== 4'd0) begin
               errors++; $display("FAIL b2b_end got=tx%b_busy%b_lvl%0d want=tx1_busy0_lvl0", tx, busy, level);
            end
         end
      end
   endtask

   task automatic test_cfg_change();
      logic [0:399] w, d;
      bit ok;
      int n;
      logic [7:0] v1;
      logic [4:0] v2;
      v1 = 8'hA5;
      v2 = 5'b10011;
      wait_idle();
      set_cfg(4'd8, 3'd0, 2'd0);
      push(9'h0A5);
      fork
         capture(330, w, d, ok);
         begin
            repeat (20) @(negedge clk);
            push(9'h013);
            repeat (20) @(negedge clk);
            set_cfg(4'd5, 3'd2, 2'd2);
         end
      join
      checks++;
      if (!ok) begin errors++; $display("FAIL cfg_start got=none want=start_bit"); return; end
      for (int b = 0; b < 8; b++) begin
         n = bad(w, 16 + 16 * b, 16, v1[b]);
         checks++; if (n != 0) begin errors++; $display("FAIL cfg_f1_data bit=%0d got=%0d_bad_cycles want=0", b, n); end
      end
      n = bad(w, 144, 16, 1'b1);
      checks++; if (n != 0) begin errors++; $display("FAIL cfg_f1_stop got=%0d_bad_cycles want=0", n); end
      n = first_done(d);
      checks++; if (n != 159) begin errors++; $display("FAIL cfg_f1_done got=%0d want=159", n); end
      n = bad(w, 160, 16, 1'b0);
      checks++; if (n != 0) begin errors++; $display("FAIL cfg_f2_start got=%0d_bad_cycles want=0", n); end
      for (int b = 0; b < 5; b++) begin
         n = bad(w, 176 + 16 * b, 16, v2[b]);
         checks++; if (n != 0) begin errors++; $display("FAIL cfg_f2_data bit=%0d got=%0d_bad_cycles want=0", b, n); end
      end
      n = bad(w, 256, 16, 1'b1);
      checks++; if (n != 0) begin errors++; $display("FAIL cfg_f2_parity got=%0d_bad_cycles want=0", n); end
      n = bad(w, 272, 58, 1'b1);
      checks++; if (n != 0) begin errors++; $display("FAIL cfg_f2_stop got=%0d_bad_cycles want=0", n); end
      checks++; if (d[303] !== 1'b1) begin errors++; $display("FAIL cfg_f2_done got=%b want=1", d[303]); end
   endtask

   task automatic test_reset_mid();
      int lows;
      int busys;
      wait_idle();
      set_cfg(4'd8, 3'd0, 2'd0);
      push(9'h000);
      push(9'h000);
      repeat (38) @(negedge clk);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx got=%b want=0", tx); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL rstmid_tx got=%b want=1", tx); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL rstmid_level got=%0d want=0", level); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      lows  = 0;
      busys = 0;
      repeat (300) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
         if (busy !== 1'b0) busys++;
      end
      checks++; if (lows != 0 || busys != 0) begin errors++; $display("FAIL rstmid_after got=%0d_low_%0d_busy want=0_0", lows, busys); end
   endtask

`ifdef UART_TX_BREAK_EN
   task automatic test_break();
      logic [0:399] w, d;
      bit ok;
      int n;
      wait_idle();
      set_cfg(4'd8, 3'd0, 2'd0);
      push(9'h000);
      fork
         capture(240, w, d, ok);
         begin
            repeat (20) @(negedge clk);
            push(9'h000);
         end
         begin
            repeat (101) @(negedge clk);
            brk = 1'b1;
            repeat (100) @(negedge clk);
            brk = 1'b0;
         end
      join
      checks++;
      if (!ok) begin errors++; $display("FAIL brk_start got=none want=start_bit"); return; end
      n = bad(w, 0, 144, 1'b0);
      checks++; if (n != 0) begin errors++; $display("FAIL brk_frame_data got=%0d_bad_cycles want=0", n); end
      n = bad(w, 144, 16, 1'b1);
      checks++; if (n != 0) begin errors++; $display("FAIL brk_frame_stop got=%0d_bad_cycles want=0", n); end
      n = first_done(d);
      checks++; if (n != 159) begin errors++; $display("FAIL brk_frame_done got=%0d want=159", n); end
      n = bad(w, 160, 41, 1'b0);
      checks++; if (n != 0) begin errors++; $display("FAIL brk_low got=%0d_bad_cycles want=0", n); end
      n = bad(w, 201, 33, 1'b1);
      checks++; if (n != 0) begin errors++; $display("FAIL brk_mab got=%0d_bad_cycles want=0", n); end
      checks++; if (w[234] !== 1'b0) begin errors++; $display("FAIL brk_next_start got=%b want=0", w[234]); end
   endtask
`endif

   initial begin
      wr_if.i_data       = '0;
      wr_if.i_data_valid = 1'b0;
      test_reset();
      test_8n1();
      test_parity();
      test_short_frames();
      test_back_to_back();
      test_cfg_change();
      test_reset_mid();
`ifdef UART_TX_BREAK_EN
      test_break();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
